// File: rtl/instruction_loader.sv
// Boot-time instruction memory writer: receives a framed, XOR-checksummed byte stream,
// assembles little-endian 32-bit words, writes them out, and holds the CPU in reset until a load verifies.
module instruction_loader #(
  parameter int MEM_SIZE      = 1024,
  parameter int START_ADDRESS = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VALID,
  output logic        BYTE_READY,
  output logic        WRITE_ENABLE,
  output logic [31:0] WRITE_ADDRESS,
  output logic [31:0] WRITE_DATA,
  output logic        BUSY,
  output logic        LOAD_DONE,
  output logic        LOAD_ERROR,
  output logic        CPU_RESET
);

  localparam logic [31:0] MAX_WORDS  = 32'((MEM_SIZE - START_ADDRESS) / 4);
  localparam logic [31:0] BASE_ADDR  = 32'(START_ADDRESS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state, state_next;
  logic [7:0]  len_lo;
  logic [15:0] words_left;
  logic [1:0]  byte_idx;
  logic [23:0] byte_buf;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [7:0]  csum;
  logic        accept;
  logic [15:0] frame_len;

  assign accept    = BYTE_VALID & BYTE_READY;
  assign frame_len = {BYTE_IN, len_lo};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    BYTE_READY   = 1'b0;
    BUSY         = 1'b1;
    WRITE_ENABLE = 1'b0;
    LOAD_DONE    = 1'b0;
    LOAD_ERROR   = 1'b0;
    CPU_RESET    = 1'b1;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        BUSY       = 1'b0;
        LOAD_DONE  = (state == S_DONE);
        LOAD_ERROR = (state == S_ERROR);
        CPU_RESET  = (state != S_DONE);
        if (START) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        BYTE_READY = 1'b1;
        if (accept) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        BYTE_READY = 1'b1;
        if (accept) begin
          if ({16'd0, frame_len} > MAX_WORDS) state_next = S_ERROR;
          else if (frame_len == 16'd0)        state_next = S_CHECK;
          else                                state_next = S_DATA;
        end
      end
      S_DATA: begin
        BYTE_READY = 1'b1;
        if (accept && byte_idx == 2'd3) state_next = S_WRITE;
      end
      S_WRITE: begin
        WRITE_ENABLE = 1'b1;
        // words_left is decremented on this same edge, so 1 means this was the last word
        state_next   = (words_left != 16'd1) ? S_DATA : S_CHECK;
      end
      S_CHECK: begin
        BYTE_READY = 1'b1;
        if (accept) state_next = (BYTE_IN == csum) ? S_DONE : S_ERROR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      len_lo     <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      byte_buf   <= '0;
      addr       <= BASE_ADDR;
      wdata      <= '0;
      csum       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (START) begin
            addr     <= BASE_ADDR;
            csum     <= '0;
            byte_idx <= '0;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len_lo <= BYTE_IN;
            csum   <= csum ^ BYTE_IN;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            words_left <= frame_len;
            csum       <= csum ^ BYTE_IN;
          end
        end
        S_DATA: begin
          if (accept) begin
            csum     <= csum ^ BYTE_IN;
            byte_idx <= byte_idx + 2'd1;
            // shifting in from the top leaves {b2,b1,b0} after three bytes
            if (byte_idx == 2'd3) wdata <= {BYTE_IN, byte_buf};
            else                  byte_buf <= {BYTE_IN, byte_buf[23:8]};
          end
        end
        S_WRITE: begin
          words_left <= words_left - 16'd1;
          addr       <= addr + 32'd4;
        end
        default: ;
      endcase
    end
  end

  assign WRITE_ADDRESS = addr;
  assign WRITE_DATA    = wdata;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader: frame loads, checksum, range, backpressure, reset.
module tb_instruction_loader;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic [7:0]  BYTE_IN = '0;
  logic        BYTE_VALID = 1'b0;
  logic        BYTE_READY, WRITE_ENABLE, BUSY, LOAD_DONE, LOAD_ERROR, CPU_RESET;
  logic [31:0] WRITE_ADDRESS, WRITE_DATA;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic [31:0] wr_addr [0:7];
  logic [31:0] wr_data [0:7];

  instruction_loader #(.MEM_SIZE(1024), .START_ADDRESS(0)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID),
    .BYTE_READY(BYTE_READY), .WRITE_ENABLE(WRITE_ENABLE), .WRITE_ADDRESS(WRITE_ADDRESS),
    .WRITE_DATA(WRITE_DATA), .BUSY(BUSY), .LOAD_DONE(LOAD_DONE), .LOAD_ERROR(LOAD_ERROR),
    .CPU_RESET(CPU_RESET)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (WRITE_ENABLE === 1'b1) begin
      if (wr_count < 8) begin
        wr_addr[wr_count] = WRITE_ADDRESS;
        wr_data[wr_count] = WRITE_DATA;
      end
      wr_count++;
    end
  end

  task automatic send(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      BYTE_VALID = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
    BYTE_IN = b;
    BYTE_VALID = 1'b1;
    n = 0;
    while (BYTE_READY !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL handshake_timeout byte=%h ready=%b want 1", b, BYTE_READY);
    end else begin
      @(negedge CLK);
    end
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wr_count = 0;
    checks++;
    if (BYTE_READY !== 1'b1) begin errors++; $display("FAIL start_ready got %b want 1", BYTE_READY); end
    checks++;
    if ({BUSY, LOAD_DONE, LOAD_ERROR, CPU_RESET} !== 4'b1001) begin
      errors++; $display("FAIL start_flags busy/done/err/cpurst got %b want 1001", {BUSY, LOAD_DONE, LOAD_ERROR, CPU_RESET});
    end
  endtask

  task automatic idle_valid();
    BYTE_VALID = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({WRITE_ENABLE, BYTE_READY, BUSY, LOAD_DONE, LOAD_ERROR, CPU_RESET} !== 6'b000001) begin
      errors++;
      $display("FAIL %s_flags we/rdy/busy/done/err/cpurst got %b want 000001", tag,
               {WRITE_ENABLE, BYTE_READY, BUSY, LOAD_DONE, LOAD_ERROR, CPU_RESET});
    end
    checks++;
    if (WRITE_ADDRESS !== 32'h0 || WRITE_DATA !== 32'h0) begin
      errors++; $display("FAIL %s_addr_data got %h/%h want 0/0", tag, WRITE_ADDRESS, WRITE_DATA);
    end
  endtask

  task automatic send_good_frame(input bit gap);
    logic [7:0] f [0:10];
    f = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
    for (int i = 0; i < 11; i++) send(f[i], gap);
    idle_valid();
  endtask

  task automatic check_two_words(input string tag);
    checks++;
    if (wr_count !== 2) begin errors++; $display("FAIL %s_wr_count got %0d want 2", tag, wr_count); end
    checks++;
    if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h00000013) begin
      errors++; $display("FAIL %s_word0 got %h=%h want 00000000=00000013", tag, wr_addr[0], wr_data[0]);
    end
    checks++;
    if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h00100093) begin
      errors++; $display("FAIL %s_word1 got %h=%h want 00000004=00100093", tag, wr_addr[1], wr_data[1]);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    BYTE_VALID = 1'b1;
    BYTE_IN = 8'h55;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("post_reset_idle");
    BYTE_VALID = 1'b0;
  endtask

  task automatic test_good_load();
    pulse_start();
    send(8'h02, 0); send(8'h00, 0);
    send(8'h13, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    checks++;
    if ({WRITE_ENABLE, BYTE_READY} !== 2'b10 || WRITE_ADDRESS !== 32'h0 || WRITE_DATA !== 32'h00000013) begin
      errors++; $display("FAIL write_cycle we/rdy=%b addr=%h data=%h want 10 0 00000013",
                         {WRITE_ENABLE, BYTE_READY}, WRITE_ADDRESS, WRITE_DATA);
    end
    @(negedge CLK);
    checks++;
    if ({WRITE_ENABLE, BYTE_READY} !== 2'b01 || WRITE_ADDRESS !== 32'h4) begin
      errors++; $display("FAIL after_write we/rdy=%b addr=%h want 01 4", {WRITE_ENABLE, BYTE_READY}, WRITE_ADDRESS);
    end
    send(8'h93, 0); send(8'h00, 0); send(8'h10, 0); send(8'h00, 0);
    send(8'h92, 0);
    checks++;
    if ({BUSY, LOAD_DONE, LOAD_ERROR, CPU_RESET} !== 4'b0100) begin
      errors++; $display("FAIL good_status busy/done/err/cpurst got %b want 0100", {BUSY, LOAD_DONE, LOAD_ERROR, CPU_RESET});
    end
    idle_valid();
    check_two_words("good");
  endtask

  task automatic test_bad_checksum();
    logic [7:0] f [0:10];
    f = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h93};
    pulse_start();
    for (int i = 0; i < 11; i++) send(f[i], 0);
    idle_valid();
    check_two_words("badsum");
    checks++;
    if ({BUSY, LOAD_DONE, LOAD_ERROR, CPU_RESET} !== 4'b0011) begin
      errors++; $display("FAIL badsum_status busy/done/err/cpurst got %b want 0011", {BUSY, LOAD_DONE, LOAD_ERROR, CPU_RESET});
    end
  endtask

  task automatic test_empty_and_oversize();
    pulse_start();
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    idle_valid();
    checks++;
    if (wr_count !== 0 || {LOAD_DONE, LOAD_ERROR, CPU_RESET} !== 3'b100) begin
      errors++; $display("FAIL empty writes=%0d done/err/cpurst=%b want 0 100", wr_count, {LOAD_DONE, LOAD_ERROR, CPU_RESET});
    end
    pulse_start();
    send(8'h01, 0); send(8'h01, 0);
    checks++;
    if ({BYTE_READY, BUSY, LOAD_ERROR, LOAD_DONE, CPU_RESET} !== 5'b00101) begin
      errors++; $display("FAIL oversize rdy/busy/err/done/cpurst got %b want 00101",
                         {BYTE_READY, BUSY, LOAD_ERROR, LOAD_DONE, CPU_RESET});
    end
    idle_valid();
    checks++;
    if (wr_count !== 0) begin errors++; $display("FAIL oversize_writes got %0d want 0", wr_count); end
    // N=256 is exactly the limit and must be accepted into DATA
    pulse_start();
    send(8'h00, 0); send(8'h01, 0);
    checks++;
    if ({BYTE_READY, BUSY, LOAD_ERROR} !== 3'b110) begin
      errors++; $display("FAIL limit_256 rdy/busy/err got %b want 110", {BYTE_READY, BUSY, LOAD_ERROR});
    end
    BYTE_VALID = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_backpressure();
    pulse_start();
    send(8'h01, 1); send(8'h00, 1); send(8'hEF, 1);
    BYTE_VALID = 1'b0;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    checks++;
    if ({BUSY, BYTE_READY} !== 2'b11) begin
      errors++; $display("FAIL start_ignored busy/rdy got %b want 11", {BUSY, BYTE_READY});
    end
    send(8'hBE, 1); send(8'hAD, 1); send(8'hDE, 1); send(8'h23, 1);
    idle_valid();
    checks++;
    if (wr_count !== 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL backpressure n=%0d %h=%h want 1 00000000=deadbeef", wr_count, wr_addr[0], wr_data[0]);
    end
    checks++;
    if ({LOAD_DONE, LOAD_ERROR, CPU_RESET} !== 3'b100) begin
      errors++; $display("FAIL backpressure_status got %b want 100", {LOAD_DONE, LOAD_ERROR, CPU_RESET});
    end
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    send(8'h02, 0); send(8'h00, 0); send(8'h13, 0); send(8'h00, 0); send(8'h00, 0);
    #2 RESET = 1'b1;
    #1 check_reset_outputs("mid_load_reset");
    BYTE_VALID = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    pulse_start();
    send_good_frame(0);
    check_two_words("reload");
    checks++;
    if ({LOAD_DONE, LOAD_ERROR, CPU_RESET} !== 3'b100) begin
      errors++; $display("FAIL reload_status got %b want 100", {LOAD_DONE, LOAD_ERROR, CPU_RESET});
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_empty_and_oversize();
    test_backpressure();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t want finish earlier", $time);
    $fatal(1);
  end

endmodule
